// File: rtl/uart_prog_loader_if.sv
// Bundle of the UART byte handshake and the instruction-memory upload (upg_*) bus.
// The loader uses the master modport; whatever feeds bytes and watches the write bus uses slave.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 14
);
  logic              start_i;
  logic              rx_valid_i;
  logic [7:0]        rx_data_i;
  logic              rx_ready_o;
  logic              upg_rst_o;
  logic              upg_wen_o;
  logic [ADDR_W-1:0] upg_adr_o;
  logic [31:0]       upg_dat_o;
  logic              upg_done_o;
  logic [ADDR_W:0]   word_cnt_o;
  logic              err_o;

  modport master (
    input  start_i, rx_valid_i, rx_data_i,
    output rx_ready_o, upg_rst_o, upg_wen_o, upg_adr_o, upg_dat_o,
           upg_done_o, word_cnt_o, err_o
  );

  modport slave (
    output start_i, rx_valid_i, rx_data_i,
    input  rx_ready_o, upg_rst_o, upg_wen_o, upg_adr_o, upg_dat_o,
           upg_done_o, word_cnt_o, err_o
  );
endinterface

// File: rtl/uart_prog_loader.sv
// Loads a program from a UART byte stream into instruction memory: a 2-byte little-endian
// word count, then 4 bytes per word, written to consecutive word addresses starting at 0.
module uart_prog_loader #(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  uart_prog_loader_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE
  } state_t;

  localparam int          TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

  state_t           state;
  logic [15:0]      len;
  logic [1:0]       byte_idx;
  logic [TMO_W-1:0] tmo_cnt;

  logic        fire;
  logic        tmo_hit;
  logic [31:0] cnt_next;
  logic [15:0] len_full;

  assign fire     = bus.rx_valid_i & bus.rx_ready_o;
  assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign cnt_next = 32'(bus.word_cnt_o) + 32'd1;
  assign len_full = {bus.rx_data_i, len[7:0]};

  // Every output is a register: each transition sets the output values of the state it enters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      len            <= '0;
      byte_idx       <= '0;
      tmo_cnt        <= '0;
      bus.rx_ready_o <= 1'b0;
      bus.upg_rst_o  <= 1'b1;
      bus.upg_wen_o  <= 1'b0;
      bus.upg_adr_o  <= '0;
      bus.upg_dat_o  <= '0;
      bus.upg_done_o <= 1'b0;
      bus.word_cnt_o <= '0;
      bus.err_o      <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees the pre-edge values and the
      // single-cycle strobes below can be defaulted low and overridden later in the block.
      bus.upg_wen_o  <= 1'b0;
      bus.upg_done_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            state          <= S_LEN_LO;
            bus.err_o      <= 1'b0;
            bus.word_cnt_o <= '0;
            bus.upg_adr_o  <= '0;
            byte_idx       <= '0;
            tmo_cnt        <= '0;
            bus.rx_ready_o <= 1'b1;
            bus.upg_rst_o  <= 1'b0;
          end
        end

        S_LEN_LO, S_LEN_HI, S_DATA: begin
          if (fire) begin
            tmo_cnt <= '0;
            case (state)
              S_LEN_LO: begin
                len[7:0] <= bus.rx_data_i;
                state    <= S_LEN_HI;
              end
              S_LEN_HI: begin
                len[15:8] <= bus.rx_data_i;
                if (len_full == 16'd0) begin
                  state          <= S_DONE;
                  bus.rx_ready_o <= 1'b0;
                  bus.upg_done_o <= 1'b1;
                end else if ({16'd0, len_full} > MAX_WORDS) begin
                  state          <= S_IDLE;
                  bus.err_o      <= 1'b1;
                  bus.rx_ready_o <= 1'b0;
                  bus.upg_rst_o  <= 1'b1;
                end else begin
                  state <= S_DATA;
                end
              end
              default: begin
                bus.upg_dat_o[{byte_idx, 3'b000} +: 8] <= bus.rx_data_i;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                  state          <= S_WRITE;
                  bus.rx_ready_o <= 1'b0;
                  bus.upg_wen_o  <= 1'b1;
                end
              end
            endcase
          end else if (tmo_hit) begin
            // Sender went quiet: abandon the load, keeping whatever words already landed.
            state          <= S_IDLE;
            bus.err_o      <= 1'b1;
            bus.rx_ready_o <= 1'b0;
            bus.upg_rst_o  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        S_WRITE: begin
          bus.upg_adr_o  <= bus.upg_adr_o + ADDR_W'(1);
          bus.word_cnt_o <= bus.word_cnt_o + (ADDR_W + 1)'(1);
          if (cnt_next == {16'd0, len}) begin
            state          <= S_DONE;
            bus.upg_done_o <= 1'b1;
          end else begin
            state          <= S_DATA;
            bus.rx_ready_o <= 1'b1;
          end
        end

        S_DONE: begin
          state         <= S_IDLE;
          bus.upg_rst_o <= 1'b1;
        end

        default: begin
          state          <= S_IDLE;
          bus.rx_ready_o <= 1'b0;
          bus.upg_rst_o  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized scoreboard bench for uart_prog_loader (ADDR_W=4, TIMEOUT_CYC=16): loads are
// described as byte streams, expected writes are derived from the stream and checked by a monitor.
module tb_uart_prog_loader;
  localparam int AW  = 4;
  localparam int TMO = 16;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [31:0]   dat;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_prog_loader_if #(.ADDR_W(AW)) bus ();

  uart_prog_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         done_seen = 0;
  wr_t        exp_wr[$];
  logic [7:0] stream[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.upg_wen_o) begin
        if (exp_wr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_wen: got adr %0h dat %0h expected no write",
                   bus.upg_adr_o, bus.upg_dat_o);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_adr", bus.upg_adr_o, e.adr);
          check("wr_dat", bus.upg_dat_o, e.dat);
        end
      end
      if (!bus.upg_rst_o && !bus.rx_ready_o && !bus.upg_done_o)
        check("ready_low_only_with_wen", bus.upg_wen_o, 1'b1);
      if (bus.upg_done_o) done_seen++;
    end
  end

  // All tasks start and end on a negative clock edge.
  task automatic do_start();
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    while (!bus.rx_ready_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("rx_ready_wait", 1'b0, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!bus.upg_rst_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("return_to_idle", 1'b0, 1'b1);
  endtask

  // Reference: N = first two bytes (LE); N==0 completes at once; N>2^AW is rejected;
  // otherwise each full group of 4 payload bytes is one LE word at address 0,1,...; a
  // stream shorter than 4*N bytes ends in a timeout after the complete words it carried.
  task automatic run_load(input bit b2b);
    int n, payload, words, consumed, done_before;
    bit exp_err, exp_done;
    n       = int'({stream[1], stream[0]});
    payload = stream.size() - 2;
    if (n == 0) begin
      words = 0; exp_done = 1'b1; exp_err = 1'b0; consumed = 2;
    end else if (n > (1 << AW)) begin
      words = 0; exp_done = 1'b0; exp_err = 1'b1; consumed = 2;
    end else begin
      words    = (payload / 4 < n) ? payload / 4 : n;
      exp_done = (payload >= 4 * n);
      exp_err  = !exp_done;
      consumed = exp_done ? 2 + 4 * n : stream.size();
    end
    for (int w = 0; w < words; w++)
      exp_wr.push_back('{adr: AW'(w),
                         dat: {stream[5+4*w], stream[4+4*w], stream[3+4*w], stream[2+4*w]}});
    done_before = done_seen;
    do_start();
    check("load_upg_rst", bus.upg_rst_o, 1'b0);
    for (int i = 0; i < consumed; i++) begin
      send_byte(stream[i]);
      if (!b2b) begin
        bus.rx_valid_i = 1'b0;
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end
    end
    bus.rx_valid_i = 1'b0;
    wait_idle();
    @(negedge clk);
    check("err", bus.err_o, exp_err);
    check("done_pulses", done_seen - done_before, exp_done);
    check("word_cnt", bus.word_cnt_o, words);
    check("pending_writes", exp_wr.size(), 0);
    check("idle_upg_rst", bus.upg_rst_o, 1'b1);
    check("idle_rx_ready", bus.rx_ready_o, 1'b0);
    exp_wr.delete();
  endtask

  task automatic random_stream(input int n, input int data_bytes);
    stream.delete();
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    for (int i = 0; i < data_bytes; i++) stream.push_back(8'($urandom));
  endtask

  initial begin
    int n, done_before;
    bus.start_i    = 1'b0;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;

    // Reset values, with a byte already offered.
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = 8'h5A;
    repeat (3) @(negedge clk);
    check("rst_upg_rst", bus.upg_rst_o, 1'b1);
    check("rst_rx_ready", bus.rx_ready_o, 1'b0);
    check("rst_wen", bus.upg_wen_o, 1'b0);
    check("rst_done", bus.upg_done_o, 1'b0);
    check("rst_err", bus.err_o, 1'b0);
    check("rst_adr", bus.upg_adr_o, '0);
    check("rst_dat", bus.upg_dat_o, '0);
    check("rst_word_cnt", bus.word_cnt_o, '0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_not_consumed", bus.rx_ready_o, 1'b0);
    bus.rx_valid_i = 1'b0;

    // Documented two-word load.
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(1'b0);

    // Empty program.
    stream = '{8'h00, 8'h00};
    run_load(1'b1);

    // Bad length: one past the memory size.
    stream = '{8'h11, 8'h00};
    run_load(1'b0);

    // Largest legal program fills every address.
    random_stream(1 << AW, 4 << AW);
    run_load(1'b1);

    // Timeout: header for one word, only two data bytes, then silence.
    done_before = done_seen;
    do_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    bus.rx_valid_i = 1'b0;
    repeat (TMO - 2) @(negedge clk);
    check("tmo_not_yet_err", bus.err_o, 1'b0);
    check("tmo_not_yet_idle", bus.upg_rst_o, 1'b0);
    repeat (3) @(negedge clk);
    check("tmo_err", bus.err_o, 1'b1);
    check("tmo_idle", bus.upg_rst_o, 1'b1);
    check("tmo_rx_ready", bus.rx_ready_o, 1'b0);
    check("tmo_word_cnt", bus.word_cnt_o, '0);
    check("tmo_no_done", done_seen - done_before, 0);

    // start_i in the middle of a load must be ignored (also clears the sticky error).
    stream = '{8'h01, 8'h00, 8'hC3, 8'hB2, 8'hA1, 8'h90};
    exp_wr.push_back('{adr: AW'(0), dat: 32'h90A1B2C3});
    done_before = done_seen;
    do_start();
    check("restart_err_cleared", bus.err_o, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(stream[i]);
    bus.rx_valid_i = 1'b0;
    do_start();
    for (int i = 4; i < 6; i++) send_byte(stream[i]);
    bus.rx_valid_i = 1'b0;
    wait_idle();
    check("ign_start_done", done_seen - done_before, 1);
    check("ign_start_word_cnt", bus.word_cnt_o, 1);
    check("ign_start_pending", exp_wr.size(), 0);
    exp_wr.delete();

    // Random loads: legal, truncated and oversized, with and without gaps.
    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(1, 1 << AW);
      if (t % 5 == 4) random_stream(n, 4 * n - $urandom_range(1, 4 * n));
      else            random_stream(n, 4 * n);
      run_load(t[0]);
    end
    for (int t = 0; t < 2; t++) begin
      random_stream($urandom_range((1 << AW) + 1, 65535), 0);
      run_load(1'b1);
    end

    // Reset in the middle of the second word.
    stream = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    exp_wr.push_back('{adr: AW'(0), dat: 32'h04030201});
    done_before = done_seen;
    do_start();
    for (int i = 0; i < 8; i++) send_byte(stream[i]);
    rst = 1'b1;
    bus.rx_valid_i = 1'b0;
    @(negedge clk);
    check("mid_rst_upg_rst", bus.upg_rst_o, 1'b1);
    check("mid_rst_rx_ready", bus.rx_ready_o, 1'b0);
    check("mid_rst_adr", bus.upg_adr_o, '0);
    check("mid_rst_dat", bus.upg_dat_o, '0);
    check("mid_rst_word_cnt", bus.word_cnt_o, '0);
    check("mid_rst_first_word_written", exp_wr.size(), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", done_seen - done_before, 0);
    check("mid_rst_stays_idle", bus.upg_rst_o, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
